// File: rtl/cla_pkg.sv
// Shared definitions for the multi-byte CLA adder: byte width, FSM state type
// and a byte-lane extraction helper.
package cla_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_W  = 1024;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    // Callers zero-extend their vector to MAX_W so one function serves any NBYTES.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [MAX_W-1:0] vec,
                                                   input int unsigned idx);
        return vec[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/carrylookahead_adder_8bit.sv
// 8-bit carry-lookahead adder slice; every carry is a flat sum of
// generate/propagate products rather than a rippled chain.
module carrylookahead_adder_8bit
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              term;
    logic              pp;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        term = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & cin);
        end
    end

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/multibyte_cla_adder.sv
// Sequential N-byte adder: feeds one byte per cycle through a single 8-bit CLA
// slice with a registered inter-byte carry. Define CLA_SUB_EN to add a sub port.
module multibyte_cla_adder
    import cla_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef CLA_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    state_t            state;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [BYTE_W-1:0] s_a;
    logic [BYTE_W-1:0] s_b;
    logic [BYTE_W-1:0] s_sum;
    logic              s_cout;
    logic [W-1:0]      b_eff;
    logic              c_init;

`ifdef CLA_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign c_init = sub ? 1'b1 : cin;
`else
    assign b_eff  = b;
    assign c_init = cin;
`endif

    assign s_a = byte_sel(MAX_W'(a_reg), 32'(idx));
    assign s_b = byte_sel(MAX_W'(b_reg), 32'(idx));

    carrylookahead_adder_8bit u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // b is stored already inverted for subtraction
                        a_reg    <= a;
                        b_reg    <= b_eff;
                        carry    <= c_init;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    sum[idx*BYTE_W +: BYTE_W] <= s_sum;
                    carry <= s_cout;
                    if (idx == IDX_LAST) begin
                        cout      <= s_cout;
                        overflow  <= (a_reg[W-1] == b_reg[W-1]) && (s_sum[BYTE_W-1] != a_reg[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/multibyte_cla_adder.md
Name: multibyte_cla_adder

Overview:
- Sequential N-byte adder. Accepts wide operands over a valid/ready handshake and adds them one byte per cycle through a single 8-bit carry-lookahead slice.
- The inter-byte carry is held in a register and chained from one byte to the next.
- The result is presented over a valid/ready handshake.
- Sits directly upstream of the 8-bit CLA: it sequences operand bytes and carry-in into the slice, and consumes its sum and carry-out.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand (≥1); total operand width W = 8*NBYTES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into byte 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  W  registered result.
- cout  out  1  carry out of the MSB byte.
- overflow  out  1  signed two's-complement overflow.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. Internal operand, carry and byte-index registers are also 0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid&in_ready: latch a, b, cin into carry register; idx=0; go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle the slice adds byte idx of A and B with the carry register.
  - At the edge: write sum[8*idx+:8]; carry register ← slice cout; idx++.
  - At the edge with idx==NBYTES-1: go to DONE instead.
  - Latch cout = slice cout.
  - Latch overflow = (a[W-1]==b_eff[W-1]) && (sum_msb != a[W-1]), computed from the MSB byte.
- DONE:
  - out_valid=1, in_ready=0.
  - sum/cout/overflow held stable until out_valid&out_ready.
  - At that edge: out_valid←0, go to IDLE.
  - sum keeps its last value after the handshake; it is not cleared.
- Latency:
  - Accept at edge E0 → out_valid high in the cycle following edge E_NBYTES, i.e. NBYTES cycles after accept.
  - Minimum turnaround accept→accept is NBYTES+2 cycles.
- No overlap: a new operand is never accepted while ADD or DONE. in_valid and operand changes during those states are ignored.
- The latched operands are used, so a and b may change after the accept edge.
- NBYTES=1: ADD lasts one cycle; behaviour is identical to a registered 8-bit add.
- Arithmetic is unsigned modulo 2^W: the carry out of byte k is the carry into byte k+1; cout is the carry out of byte NBYTES-1.
- Reset mid-operation (any state): immediate return to reset values; the partial result is discarded and no out_valid pulse is produced.
- out_ready asserted while not DONE has no effect.

Optional Feature:
- Macro CLA_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched with the operands.
  - When sub=1: b_eff = ~b and initial carry = 1, ignoring cin. sum = A−B mod 2^W.
  - cout=1 means no borrow (A≥B unsigned). overflow uses b_eff.
- Undefined: no sub port; b_eff=b; initial carry=cin.

Decomposition:
- Shared package cla_pkg holds:
  - BYTE_W=8.
  - State enum type (IDLE, ADD, DONE).
  - Function byte_sel(vec, idx) returning an 8-bit slice.
- One sub-module: carrylookahead_adder_8bit, instantiated once as the byte slice.
- FSM, operand registers, carry register and result register stay in multibyte_cla_adder.

Test Plan (NBYTES=4):
- a=0x000000FF, b=0x00000001, cin=0, accepted at edge E0 → out_valid rises after E4; sum=0x00000100, cout=0, overflow=0.
- a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. Confirms the carry chains through all 4 bytes.
- a=0x7FFFFFFF, b=0x00000000, cin=1 → sum=0x80000000, cout=0, overflow=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, overflow=1.
- Back-pressure: out_ready low for 5 cycles in DONE while in_valid=1 with new operands. Required: sum/cout/overflow stable, in_ready=0, new operands not accepted. After the out_ready handshake, in_ready=1 on the next cycle and the new operands are accepted.
- Reset: assert rst_n=0 asynchronously while idx=2 in ADD. Required: outputs at reset values immediately, in_ready=1 after release, and the next op a=0x12345678, b=0x11111111 gives sum=0x23456789, cout=0.
- CLA_SUB_EN with sub=1:
  - a=0x00000010, b=0x00000020 → sum=0xFFFFFFF0, cout=0.
  - a=5, b=3 → sum=0x00000002, cout=1.
  - a=0x80000000, b=1 → sum=0x7FFFFFFF, overflow=1.
